// File: rtl/addpipe_sched_pkg.sv
// Shared types and helpers for the round-robin scheduler in front of the
// two-stage split-carry adder core.
package addpipe_sched_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } sched_state_t;

    // Cycles from a transfer to the matching result on the output stream.
    localparam int PIPE_LAT = 3;

    // Upper bound on requesters; rr_pick works on vectors of this size.
    localparam int MAX_REQ = 16;
    localparam int PTR_W   = 4;

    // Round-robin pick: scan from ptr+1 upward, wrapping at n_req, and
    // return the first index with valid set. Returns ptr when nothing is valid.
    function automatic logic [PTR_W-1:0] rr_pick(
        input logic [MAX_REQ-1:0] valid,
        input logic [PTR_W-1:0]   ptr,
        input int unsigned        n_req
    );
        logic [PTR_W-1:0] pick;
        logic             found;
        int unsigned      idx;
        logic [PTR_W-1:0] idx_s;
        pick  = ptr;
        found = 1'b0;
        for (int unsigned k = 1; k <= MAX_REQ; k++) begin
            if (k <= n_req) begin
                idx   = (32'(ptr) + k) % n_req;
                idx_s = idx[PTR_W-1:0];
                if (!found && valid[idx_s]) begin
                    pick  = idx_s;
                    found = 1'b1;
                end
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/addpipe.sv
// Two-stage split-carry adder core. The low segment is added in the first
// stage and its carry is registered; the high segment consumes that carry in
// the second stage. Latency 2, one operation per cycle, carry-out exposed.
module addpipe #(
    parameter int LS_WIDTH = 32,
    parameter int MS_WIDTH = 32
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic [LS_WIDTH+MS_WIDTH-1:0] a,
    input  logic [LS_WIDTH+MS_WIDTH-1:0] b,
    output logic [LS_WIDTH+MS_WIDTH-1:0] sum,
    output logic                         cout
);

    localparam int W = LS_WIDTH + MS_WIDTH;

    logic [LS_WIDTH:0]   ls_sum;
    logic [LS_WIDTH-1:0] ls_sum_p1;
    logic                carry_p1;
    logic [MS_WIDTH-1:0] a_ms_p1;
    logic [MS_WIDTH-1:0] b_ms_p1;
    logic [MS_WIDTH:0]   ms_sum;

    assign ls_sum = {1'b0, a[LS_WIDTH-1:0]} + {1'b0, b[LS_WIDTH-1:0]};

    // Stage p1: low segment sum and its carry, high operands carried along
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ls_sum_p1 <= '0;
            carry_p1  <= 1'b0;
            a_ms_p1   <= '0;
            b_ms_p1   <= '0;
        end else begin
            ls_sum_p1 <= ls_sum[LS_WIDTH-1:0];
            carry_p1  <= ls_sum[LS_WIDTH];
            a_ms_p1   <= a[W-1:LS_WIDTH];
            b_ms_p1   <= b[W-1:LS_WIDTH];
        end
    end

    assign ms_sum = {1'b0, a_ms_p1} + {1'b0, b_ms_p1} + {{MS_WIDTH{1'b0}}, carry_p1};

    // Stage p2: high segment absorbs the carry; full sum and carry-out registered
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sum  <= '0;
            cout <= 1'b0;
        end else begin
            sum  <= {ms_sum[MS_WIDTH-1:0], ls_sum_p1};
            cout <= ms_sum[MS_WIDTH];
        end
    end

endmodule

// File: rtl/addpipe_rr_sched.sv
// Round-robin scheduler sharing one addpipe core among N_REQ requesters.
// One grant per cycle; each op is tagged with its requester id and returned
// as {id, sum} three cycles after the transfer, in issue order.
// Optional macro ADDPIPE_RR_SCHED_OVF_EN adds res_ovf (adder carry-out,
// aligned with res_sum).
module addpipe_rr_sched
    import addpipe_sched_pkg::*;
#(
    parameter int N_REQ    = 4,
    parameter int LS_WIDTH = 32,
    parameter int MS_WIDTH = 32,
    parameter int WIDTH    = LS_WIDTH + MS_WIDTH,
    localparam int ID_W    = $clog2(N_REQ)
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [N_REQ-1:0]       req_valid,
    output logic [N_REQ-1:0]       req_ready,
    input  logic [N_REQ*WIDTH-1:0] req_a,
    input  logic [N_REQ*WIDTH-1:0] req_b,
    input  logic                   hold,
    output logic                   res_valid,
    output logic [ID_W-1:0]        res_id,
    output logic [WIDTH-1:0]       res_sum,
`ifdef ADDPIPE_RR_SCHED_OVF_EN
    output logic                   res_ovf,
`endif
    output logic                   idle
);

    localparam int CNT_W = $clog2(PIPE_LAT + 1);

    if (WIDTH != LS_WIDTH + MS_WIDTH) begin : g_width_chk
        $fatal(1, "addpipe_rr_sched: WIDTH must equal LS_WIDTH + MS_WIDTH");
    end
    if (N_REQ < 2 || N_REQ > MAX_REQ) begin : g_nreq_chk
        $fatal(1, "addpipe_rr_sched: N_REQ must be in 2..16");
    end

    sched_state_t     state;
    logic [ID_W-1:0]  rr_ptr;
    logic [PTR_W-1:0] pick;
    logic [ID_W-1:0]  grant_id;
    logic             any_valid;
    logic             grant_ok;
    logic             transfer;
    logic [CNT_W-1:0] inflight;
    logic [WIDTH-1:0] sel_a;
    logic [WIDTH-1:0] sel_b;

    logic [WIDTH-1:0] a_p0;
    logic [WIDTH-1:0] b_p0;
    logic [ID_W-1:0]  id_p0;
    logic             vld_p0;
    logic [ID_W-1:0]  id_p1;
    logic             vld_p1;
    logic [WIDTH-1:0] sum_p2;
    logic             cout_p2;

    assign pick      = rr_pick(MAX_REQ'(req_valid), PTR_W'(rr_ptr), N_REQ);
    assign grant_id  = ID_W'(pick);
    assign any_valid = |req_valid;
    // DRAIN and hold both block new grants; IDLE and RUN grant freely.
    assign grant_ok  = !hold && (state != DRAIN);

    // Grant is one-hot on the picked requester, or zero when nothing may issue
    always_comb begin
        req_ready = '0;
        if (grant_ok && any_valid) begin
            req_ready[grant_id] = 1'b1;
        end
    end

    assign transfer = |(req_valid & req_ready);

    // Operand mux for the granted requester
    always_comb begin
        int base;
        base  = int'(grant_id) * WIDTH;
        sel_a = req_a[base +: WIDTH];
        sel_b = req_b[base +: WIDTH];
    end

    // Round-robin pointer moves only on a completed transfer
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rr_ptr <= ID_W'(N_REQ - 1);
        end else if (transfer) begin
            rr_ptr <= grant_id;
        end
    end

    // Stage p0: issue register; operands hold their old value when idle
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            a_p0   <= '0;
            b_p0   <= '0;
            id_p0  <= '0;
            vld_p0 <= 1'b0;
        end else begin
            vld_p0 <= transfer;
            if (transfer) begin
                a_p0  <= sel_a;
                b_p0  <= sel_b;
                id_p0 <= grant_id;
            end
        end
    end

    addpipe #(
        .LS_WIDTH (LS_WIDTH),
        .MS_WIDTH (MS_WIDTH)
    ) u_addpipe (
        .clock (clock),
        .reset (reset),
        .a     (a_p0),
        .b     (b_p0),
        .sum   (sum_p2),
        .cout  (cout_p2)
    );

    // Stage p1/p2: tag and valid follow the adder; p2 is the output register
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            id_p1     <= '0;
            vld_p1    <= 1'b0;
            res_id    <= '0;
            res_valid <= 1'b0;
        end else begin
            id_p1     <= id_p0;
            vld_p1    <= vld_p0;
            res_id    <= id_p1;
            res_valid <= vld_p1;
        end
    end

    assign res_sum = sum_p2;

`ifdef ADDPIPE_RR_SCHED_OVF_EN
    assign res_ovf = cout_p2;
`else
    logic ovf_unused;
    assign ovf_unused = cout_p2;
`endif

    // Scheduler FSM and in-flight counter (issue +1, retire -1)
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            inflight <= '0;
        end else begin
            case ({transfer, res_valid})
                2'b10:   inflight <= inflight + 1'b1;
                2'b01:   inflight <= inflight - 1'b1;
                default: inflight <= inflight;
            endcase
            unique case (state)
                IDLE: begin
                    if (transfer) state <= RUN;
                end
                RUN: begin
                    if (hold)                               state <= DRAIN;
                    else if (!transfer && inflight == '0)   state <= IDLE;
                end
                DRAIN: begin
                    if (inflight == '0) state <= IDLE;
                    else if (!hold)     state <= RUN;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign idle = (state == IDLE) && (inflight == '0);

endmodule

// File: tb/tb_addpipe_rr_sched.sv
// Directed bench for addpipe_rr_sched with a result scoreboard: each expected
// grant pushes {id, a+b, due cycle}; the result monitor pops and compares.
module tb_addpipe_rr_sched;

    localparam int N = 4;
    localparam int W = 64;

    logic           clock = 1'b0;
    logic           reset = 1'b0;
    logic [N-1:0]   req_valid;
    logic [N-1:0]   req_ready;
    logic [N*W-1:0] req_a;
    logic [N*W-1:0] req_b;
    logic           hold;
    logic           res_valid;
    logic [1:0]     res_id;
    logic [W-1:0]   res_sum;
`ifdef ADDPIPE_RR_SCHED_OVF_EN
    logic           res_ovf;
`endif
    logic           idle;

    logic [W-1:0] opa [N];
    logic [W-1:0] opb [N];

    typedef struct {
        logic [1:0]   id;
        logic [W-1:0] sum;
`ifdef ADDPIPE_RR_SCHED_OVF_EN
        logic         ovf;
`endif
        int           due;
    } exp_t;

    exp_t sb [$];
    exp_t mon_e;
    int   cyc      = 0;
    int   n_checks = 0;
    int   n_fail   = 0;

    assign req_a = {opa[3], opa[2], opa[1], opa[0]};
    assign req_b = {opb[3], opb[2], opb[1], opb[0]};

    addpipe_rr_sched dut (
        .clock     (clock),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .hold      (hold),
        .res_valid (res_valid),
        .res_id    (res_id),
        .res_sum   (res_sum),
`ifdef ADDPIPE_RR_SCHED_OVF_EN
        .res_ovf   (res_ovf),
`endif
        .idle      (idle)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Check the grant at the negedge and record the expected result.
    task automatic step_chk(input logic [N-1:0] exp_ready);
        exp_t         e;
        logic [W:0]   full;
        @(negedge clock);
        chk("req_ready", W'(req_ready), W'(exp_ready));
        for (int i = 0; i < N; i++) begin
            if (exp_ready[i]) begin
                full  = {1'b0, opa[i]} + {1'b0, opb[i]};
                e.id  = 2'(i);
                e.sum = full[W-1:0];
`ifdef ADDPIPE_RR_SCHED_OVF_EN
                e.ovf = full[W];
`endif
                e.due = cyc + 3;
                sb.push_back(e);
            end
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic step(input logic [N-1:0] exp_ready);
        step_chk(exp_ready);
        tick();
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, "_res_valid"}, W'(res_valid), '0);
        chk({tag, "_res_id"},    W'(res_id),    '0);
        chk({tag, "_res_sum"},   res_sum,       '0);
        chk({tag, "_idle"},      W'(idle),      W'(1));
        chk({tag, "_req_ready"}, W'(req_ready), '0);
    endtask

    // Result monitor: every res_valid must match the head of the scoreboard
    always @(negedge clock) begin
        if (!reset) begin
            if (res_valid === 1'b1) begin
                chk("res_expected", W'(sb.size() > 0), W'(1));
                if (sb.size() > 0) begin
                    mon_e = sb.pop_front();
                    chk("res_id",    W'(res_id), W'(mon_e.id));
                    chk("res_sum",   res_sum,    mon_e.sum);
                    chk("res_cycle", W'(cyc),    W'(mon_e.due));
`ifdef ADDPIPE_RR_SCHED_OVF_EN
                    chk("res_ovf",   W'(res_ovf), W'(mon_e.ovf));
`endif
                end
            end else if (sb.size() > 0 && sb[0].due <= cyc) begin
                chk("res_missing", W'(res_valid), W'(1));
                void'(sb.pop_front());
            end
        end
    end

    initial begin
        logic [N-1:0] ex;
        hold      = 1'b0;
        req_valid = '0;
        for (int i = 0; i < N; i++) begin
            opa[i] = '0;
            opb[i] = '0;
        end

        // Reset state
        #1 reset = 1'b1;
        #2 chk_quiet("reset");
        repeat (2) @(posedge clock);
        #1 reset = 1'b0;

        // Fairness: all four requesters streaming
        for (int i = 0; i < N; i++) begin
            opa[i] = {$urandom, $urandom};
            opb[i] = {$urandom, $urandom};
        end
        req_valid = 4'hF;
        for (int s = 0; s < 8; s++) begin
            ex = 4'b0001 << (s % 4);
            step(ex);
            opa[s % 4] = {$urandom, $urandom};
            opb[s % 4] = {$urandom, $urandom};
        end
        req_valid = '0;
        repeat (6) step('0);
        @(negedge clock);
        chk("idle_after_stream", W'(idle), W'(1));
        tick();

        // Wrap-around: all-ones + 1
        opa[0] = '1;
        opb[0] = 64'd1;
        req_valid = 4'b0001;
        step(4'b0001);
        req_valid = '0;
        repeat (6) step('0);

        // Single requester with a carry across the segment boundary
        opa[0] = 64'h0000_0001_FFFF_FFFF;
        opb[0] = 64'd1;
        req_valid = 4'b0001;
        step(4'b0001);
        req_valid = '0;
        repeat (6) step('0);

        // Sparse: req 2, then req 1 five cycles later with the block idle
        opa[2] = {$urandom, $urandom};
        opb[2] = {$urandom, $urandom};
        opa[1] = {$urandom, $urandom};
        opb[1] = {$urandom, $urandom};
        req_valid = 4'b0100;
        step(4'b0100);
        req_valid = '0;
        repeat (4) step('0);
        req_valid = 4'b0010;
        step_chk(4'b0010);
        chk("idle_gap", W'(idle), W'(1));
        tick();
        req_valid = '0;
        repeat (6) step('0);

        // hold during streaming, then resume at pointer+1
        req_valid = 4'hF;
        step(4'b0100);
        step(4'b1000);
        step(4'b0001);
        step(4'b0010);
        hold = 1'b1;
        repeat (8) step('0);
        @(negedge clock);
        chk("idle_after_hold", W'(idle), W'(1));
        tick();
        hold = 1'b0;
        step(4'b0100);
        req_valid = '0;
        repeat (6) step('0);

        // Reset with three ops in flight
        req_valid = 4'hF;
        step(4'b1000);
        step(4'b0001);
        step(4'b0010);
        reset     = 1'b1;
        req_valid = '0;
        sb.delete();
        tick();
        reset = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clock);
            chk_quiet("post_reset");
            tick();
        end

        // Recovery after reset: pointer back to N-1, requester 0 wins
        opa[3] = {$urandom, $urandom};
        opb[3] = {$urandom, $urandom};
        req_valid = 4'b1001;
        step(4'b0001);
        req_valid = '0;
        repeat (5) step('0);

        // Bounded drain of anything still expected
        for (int k = 0; k < 20 && sb.size() > 0; k++) tick();
        chk("scoreboard_drained", W'(sb.size()), '0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/addpipe_rr_sched.md
Name: addpipe_rr_sched

Overview:
- Round-robin scheduler that shares one two-stage split-carry adder core (addpipe, latency 2, async reset) among N_REQ requesters.
- Each requester presents an operand pair with a valid/ready handshake.
- The block grants one requester per cycle and registers the selected operands into the adder.
- It tags each operation with the requester ID through a matching pipeline and returns {id, sum} on a shared result stream.
- Sits between arithmetic clients (accumulators, address generators) and the shared wide adder.

Parameters:
- N_REQ, 4, number of requesters (2..16)
- LS_WIDTH, 32, low adder segment width
- MS_WIDTH, 32, high adder segment width
- WIDTH, LS_WIDTH+MS_WIDTH, operand/result width; any other value -> $fatal at elaboration
- ID_W, $clog2(N_REQ), requester ID width (localparam-derived, not overridable)

Ports:
- clock  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- req_valid  in  N_REQ  per-requester operand valid
- req_ready  out  N_REQ  per-requester grant; one-hot or zero
- req_a  in  N_REQ*WIDTH  operand A, requester i at [i*WIDTH +: WIDTH]
- req_b  in  N_REQ*WIDTH  operand B, same packing
- hold  in  1  stop issuing new grants; in-flight ops complete
- res_valid  out  1  result valid (single cycle, no backpressure)
- res_id  out  ID_W  requester that issued the result
- res_sum  out  WIDTH  (a+b) mod 2^WIDTH
- idle  out  1  high when no op is in flight and state is IDLE

Behaviour:
- Reset values: req_ready=0, res_valid=0, res_id=0, res_sum=0, idle=1, rr pointer=N_REQ-1 (requester 0 has top priority), tag/valid pipeline cleared, state=IDLE.
- Arbitration:
  - Search starts at (last_grant+1) mod N_REQ and wraps; the first requester with req_valid high is granted.
  - req_ready is combinational from req_valid, hold and state.
  - At most one bit of req_ready is high in any cycle.
  - The pointer updates only on a completed transfer (req_valid[i] & req_ready[i]).
- Issue: on a transfer, the operands and id are captured into an issue register, with issue_v=1.
  - With no transfer, issue_v=0 and the operand registers keep their old values. The adder still computes on them, but the result is suppressed by the valid pipeline.
- Latency: the transfer cycle is cycle 0; res_valid/res_id/res_sum are valid in cycle 3.
  - Fixed latency, one op per cycle throughput, results in issue order.
- Tag pipeline: issue_v/id are delayed 2 stages alongside the adder. res_valid and res_id are registered, aligned with the adder output register.
- States:
  - IDLE: no in-flight ops.
    - IDLE -> RUN on any transfer.
  - RUN: grants allowed.
    - RUN -> DRAIN when hold=1.
    - RUN -> IDLE when no transfer this cycle and the in-flight count is 0.
  - DRAIN: req_ready=0.
    - DRAIN -> IDLE when the in-flight count reaches 0.
    - DRAIN -> RUN when hold=0 before the count reaches 0.
- hold gates grants in every state; hold=1 in IDLE keeps the block in IDLE with no grants.
- In-flight count: 0..3, +1 on transfer, -1 on res_valid, both in one cycle -> unchanged. idle = (state==IDLE) & (count==0).
- Overflow: the carry out of bit WIDTH-1 is discarded (wrap-around), e.g. all-ones + 1 = 0.
- Reset mid-operation: all in-flight results are dropped; no res_valid after reset deasserts until a new transfer plus 3 cycles.
- req_valid deasserted without ready is legal; the block keeps no request state.

Optional Feature:
- Macro: ADDPIPE_RR_SCHED_OVF_EN.
- Defined:
  - Adds output port res_ovf (1 bit) carrying the adder core's msb/carry-out, registered and aligned with res_sum.
  - res_ovf resets to 0 and is valid only with res_valid.
- Undefined: the port is absent and the carry is ignored.

Decomposition:
- Package addpipe_sched_pkg:
  - state enum sched_state_t {IDLE, RUN, DRAIN}
  - localparam PIPE_LAT=3
  - function rr_pick(valid, ptr) returning the next grant index.
- Sub-module: addpipe (existing adder core), instantiated once.
- The arbiter and tag pipeline stay in this module.

Test Plan:
- Single requester: req 0 only, a=0x0000_0001_FFFF_FFFF, b=1 -> res_sum=0x0000_0002_0000_0000, res_id=0, cycle 3 after transfer (cross-segment carry).
- Fairness: all 4 valid continuously for 8 cycles -> grants 0,1,2,3,0,1,2,3; results back-to-back in the same id order.
- Wrap: a=all-ones, b=1 -> res_sum=0, res_ovf=1 (macro on).
- hold: assert hold during streaming -> req_ready=0 next cycle, last 2-3 results still emitted, then idle=1; deassert -> grants resume at pointer+1.
- Sparse: req 2 at cycle 0, req 1 at cycle 5 -> res_id=2 at cycle 3, res_id=1 at cycle 8, idle high in between.
- Reset with 3 ops in flight -> no res_valid for the following 5 cycles, all outputs 0, idle=1.
